prio_encoder_arb: RTL and testbench

- Parametrised, registered successor to the team's 4-to-2 combinational priority encoder.
- Takes an N-bit request vector and produces a registered winner index, one-hot grant and multi-request flag behind a valid/ready output handshake.
- Supports fixed-priority (highest index wins) or round-robin selection.
- Sits between request sources (interrupt lines, channel requests) and a single downstream consumer.

---
 rtl/prio_encoder_arb.sv | 67 ++++++
 tb/tb_prio_encoder_arb.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/prio_encoder_arb.sv
// Registered priority encoder / arbiter: N-bit request vector in, winner index,
// one-hot grant and multi-request flag out behind a valid/ready handshake.
module prio_encoder_arb #(
  parameter int unsigned N    = 8,
  parameter int unsigned W    = $clog2(N),
  parameter int unsigned MODE = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_onehot,
  output logic         out_multi
);

  logic [W-1:0] ptr;
  logic [W-1:0] sel;
  logic         hit;
  logic         load;
  int unsigned  j;

  assign load = !out_valid || out_ready;

  // Round-robin search visits ptr-1, ptr-2, ..., ptr (mod N); first set bit wins.
  always_comb begin
    sel = '0;
    hit = 1'b0;
    j   = 0;
    if (MODE == 0) begin
      for (int unsigned i = 0; i < N; i++) begin
        if ((req & (N'(1) << i)) != '0) begin
          sel = W'(i);
          hit = 1'b1;
        end
      end
    end else begin
      for (int unsigned k = 1; k <= N; k++) begin
        j = (32'(ptr) + N - k) % N;
        if (!hit && ((req & (N'(1) << j)) != '0)) begin
          sel = W'(j);
          hit = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_idx    <= '0;
      out_onehot <= '0;
      out_multi  <= 1'b0;
      ptr        <= '0;
    end else if (load) begin
      out_valid  <= hit;
      out_idx    <= hit ? sel : '0;
      out_onehot <= hit ? (N'(1) << sel) : '0;
      out_multi  <= hit && ($countones(req) > 1);
      if ((MODE != 0) && hit) begin
        ptr <= sel;
      end
    end
  end

endmodule

// File: tb/tb_prio_encoder_arb.sv
// Self-checking bench for prio_encoder_arb: directed vectors on four configurations
// plus randomized traffic compared against a behavioural arbitration model.
module tb_prio_encoder_arb;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] rdy = '0;
  logic [3:0] rq0, rq1;
  logic [4:0] rq2;
  logic [7:0] rq3;

  logic       v0, v1, v2, v3, m0, m1, m2, m3;
  logic [1:0] i0, i1;
  logic [2:0] i2, i3;
  logic [3:0] h0, h1;
  logic [4:0] h2;
  logic [7:0] h3;

  logic       a_v[4];
  int         a_idx[4];
  logic [7:0] a_oh[4];
  logic       a_mu[4];
  logic [7:0] cur_req[4];

  logic       m_v[4];
  int         m_idx[4];
  logic       m_mu[4];
  int         m_ptr[4];

  int ns[4] = '{4, 4, 5, 8};
  int ms[4] = '{0, 1, 1, 0};

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0] req;
    logic       v;
    int         idx;
    logic       mu;
  } vec_t;
  vec_t tbl[16];

  always #5 clk = ~clk;

  prio_encoder_arb #(.N(4), .MODE(0)) u_fp4 (
    .clk(clk), .rst(rst), .req(rq0), .out_ready(rdy[0]),
    .out_valid(v0), .out_idx(i0), .out_onehot(h0), .out_multi(m0));
  prio_encoder_arb #(.N(4), .MODE(1)) u_rr4 (
    .clk(clk), .rst(rst), .req(rq1), .out_ready(rdy[1]),
    .out_valid(v1), .out_idx(i1), .out_onehot(h1), .out_multi(m1));
  prio_encoder_arb #(.N(5), .MODE(1)) u_rr5 (
    .clk(clk), .rst(rst), .req(rq2), .out_ready(rdy[2]),
    .out_valid(v2), .out_idx(i2), .out_onehot(h2), .out_multi(m2));
  prio_encoder_arb u_def (
    .clk(clk), .rst(rst), .req(rq3), .out_ready(rdy[3]),
    .out_valid(v3), .out_idx(i3), .out_onehot(h3), .out_multi(m3));

  always_comb begin
    a_v[0] = v0; a_idx[0] = int'(i0); a_oh[0] = {4'b0, h0}; a_mu[0] = m0;
    a_v[1] = v1; a_idx[1] = int'(i1); a_oh[1] = {4'b0, h1}; a_mu[1] = m1;
    a_v[2] = v2; a_idx[2] = int'(i2); a_oh[2] = {3'b0, h2}; a_mu[2] = m2;
    a_v[3] = v3; a_idx[3] = int'(i3); a_oh[3] = h3;         a_mu[3] = m3;
    cur_req[0] = {4'b0, rq0};
    cur_req[1] = {4'b0, rq1};
    cur_req[2] = {3'b0, rq2};
    cur_req[3] = rq3;
  end

  // Winner by policy: fixed = highest set index; round-robin = first set bit
  // walking downward from p-1, wrapping modulo n. -1 when nothing requests.
  function automatic int pick(input int n, input int mode, input logic [7:0] r, input int p);
    int q;
    if (mode == 0) begin
      for (int i = n - 1; i >= 0; i--) if (r[i]) return i;
    end else begin
      for (int k = 1; k <= n; k++) begin
        q = (p - k + n) % n;
        if (r[q]) return q;
      end
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (rst) begin
        m_v[k] <= 1'b0; m_idx[k] <= 0; m_mu[k] <= 1'b0; m_ptr[k] <= 0;
      end else if (!m_v[k] || rdy[k]) begin
        if (pick(ns[k], ms[k], cur_req[k], m_ptr[k]) < 0) begin
          m_v[k] <= 1'b0; m_idx[k] <= 0; m_mu[k] <= 1'b0;
        end else begin
          m_v[k]   <= 1'b1;
          m_idx[k] <= pick(ns[k], ms[k], cur_req[k], m_ptr[k]);
          m_mu[k]  <= ($countones(cur_req[k]) >= 2);
          if (ms[k] == 1) m_ptr[k] <= pick(ns[k], ms[k], cur_req[k], m_ptr[k]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input int k, input logic ev, input int ei, input logic em, input string nm);
    logic [7:0] eoh;
    eoh = ev ? (8'd1 << ei) : 8'd0;
    n_chk++;
    if (a_v[k] !== ev || a_idx[k] != ei || a_oh[k] !== eoh || a_mu[k] !== em) begin
      n_fail++;
      $display("FAIL %s dut%0d: got valid=%0b idx=%0d onehot=%b multi=%0b, expected valid=%0b idx=%0d onehot=%b multi=%0b",
               nm, k, a_v[k], a_idx[k], a_oh[k], a_mu[k], ev, ei, eoh, em);
    end
  endtask

  initial begin
    int rr4_seq[6];
    int sp4_seq[4];
    int sp5_seq[4];

    tbl[0]  = '{4'b0000, 1'b0, 0, 1'b0};
    tbl[1]  = '{4'b0001, 1'b1, 0, 1'b0};
    tbl[2]  = '{4'b0010, 1'b1, 1, 1'b0};
    tbl[3]  = '{4'b0011, 1'b1, 1, 1'b1};
    tbl[4]  = '{4'b0100, 1'b1, 2, 1'b0};
    tbl[5]  = '{4'b0101, 1'b1, 2, 1'b1};
    tbl[6]  = '{4'b0110, 1'b1, 2, 1'b1};
    tbl[7]  = '{4'b0111, 1'b1, 2, 1'b1};
    tbl[8]  = '{4'b1000, 1'b1, 3, 1'b0};
    tbl[9]  = '{4'b1001, 1'b1, 3, 1'b1};
    tbl[10] = '{4'b1010, 1'b1, 3, 1'b1};
    tbl[11] = '{4'b1011, 1'b1, 3, 1'b1};
    tbl[12] = '{4'b1100, 1'b1, 3, 1'b1};
    tbl[13] = '{4'b1101, 1'b1, 3, 1'b1};
    tbl[14] = '{4'b1110, 1'b1, 3, 1'b1};
    tbl[15] = '{4'b1111, 1'b1, 3, 1'b1};
    rr4_seq = '{3, 2, 1, 0, 3, 2};
    sp4_seq = '{3, 1, 3, 1};
    sp5_seq = '{4, 0, 4, 0};

    // Reset dominates even with all requests up
    rst = 1'b1; rdy = '0;
    rq0 = 4'hf; rq1 = 4'hf; rq2 = 5'h1f; rq3 = 8'hff;
    step(); step();
    for (int k = 0; k < 4; k++) expect_v(k, 1'b0, 0, 1'b0, "reset");
    rst = 1'b0; rdy = 4'hf;
    step();
    expect_v(0, 1'b1, 3, 1'b1, "post_reset");
    expect_v(1, 1'b1, 3, 1'b1, "post_reset");
    expect_v(2, 1'b1, 4, 1'b1, "post_reset");
    expect_v(3, 1'b1, 7, 1'b1, "post_reset");

    for (int t = 0; t < 16; t++) begin
      rq0 = tbl[t].req;
      step();
      expect_v(0, tbl[t].v, tbl[t].idx, tbl[t].mu, "fp_sweep");
    end

    rq0 = 4'b0100;
    step();
    expect_v(0, 1'b1, 2, 1'b0, "stall_setup");
    rdy[0] = 1'b0; rq0 = 4'b1000;
    for (int t = 0; t < 3; t++) begin
      step();
      expect_v(0, 1'b1, 2, 1'b0, "stall_hold");
    end
    rdy[0] = 1'b1;
    step();
    expect_v(0, 1'b1, 3, 1'b0, "stall_release");

    rst = 1'b1; step(); rst = 1'b0;
    rq1 = 4'hf; rdy = 4'hf;
    for (int t = 0; t < 6; t++) begin
      step();
      expect_v(1, 1'b1, rr4_seq[t], 1'b1, "rr_full");
    end

    rst = 1'b1; step(); rst = 1'b0;
    rq1 = 4'b1010; rq2 = 5'b10001;
    for (int t = 0; t < 4; t++) begin
      step();
      expect_v(1, 1'b1, sp4_seq[t], 1'b1, "rr_sparse4");
      expect_v(2, 1'b1, sp5_seq[t], 1'b1, "rr_sparse5");
    end

    rst = 1'b1; step(); rst = 1'b0;
    rq1 = 4'hf;
    step(); step(); step();
    expect_v(1, 1'b1, 1, 1'b1, "rr_reach1");
    rdy[1] = 1'b0;
    step(); step();
    expect_v(1, 1'b1, 1, 1'b1, "rr_stall");
    rst = 1'b1;
    step();
    expect_v(1, 1'b0, 0, 1'b0, "mid_reset");
    rst = 1'b0; rdy[1] = 1'b1;
    step();
    expect_v(1, 1'b1, 3, 1'b1, "after_mid_reset");

    for (int t = 0; t < 600; t++) begin
      rq0 = 4'($urandom);
      rq1 = 4'($urandom);
      rq2 = 5'($urandom);
      rq3 = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      for (int k = 0; k < 4; k++) rdy[k] = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 59) == 0);
      step();
      for (int k = 0; k < 4; k++) expect_v(k, m_v[k], m_idx[k], m_mu[k], "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
